// File: rtl/fp_subtractor_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (A - B), truncating, no special values.
// Walks IDLE -> ALIGN -> ADD -> NORM -> DONE with a valid/ready handshake on each side.
module fp_subtractor_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] diff,
  output logic        overflow,
  output logic        underflow,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_r;
  logic        sign_a_r;
  logic        sign_b_r;
  logic [7:0]  exp_a_r;
  logic [7:0]  exp_b_r;
  logic [24:0] man_a_r;
  logic [24:0] man_b_r;
  logic [4:0]  shift_cnt_r;
  logic        res_sign_r;
  logic [7:0]  res_exp_r;
  logic [24:0] res_man_r;
  logic [31:0] diff_r;
  logic        overflow_r;
  logic        underflow_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic        busy_r;

  logic        a_zero_s;
  logic        b_zero_s;
  logic [8:0]  exp_inc_s;

  // Operand zero detection and the widened exponent used for the right-normalise step
  always_comb begin
    a_zero_s  = (A[30:0] == 31'd0);
    b_zero_s  = (B[30:0] == 31'd0);
    exp_inc_s = {1'b0, res_exp_r} + 9'd1;
  end

  // Main sequencer: datapath registers and registered handshake outputs move together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      sign_a_r    <= 1'b0;
      sign_b_r    <= 1'b0;
      exp_a_r     <= 8'd0;
      exp_b_r     <= 8'd0;
      man_a_r     <= 25'd0;
      man_b_r     <= 25'd0;
      shift_cnt_r <= 5'd0;
      res_sign_r  <= 1'b0;
      res_exp_r   <= 8'd0;
      res_man_r   <= 25'd0;
      diff_r      <= 32'd0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is done as A + (-B), so the subtrahend sign flips here
            sign_a_r    <= A[31];
            sign_b_r    <= ~B[31];
            exp_a_r     <= A[30:23];
            exp_b_r     <= B[30:23];
            man_a_r     <= {2'b01, A[22:0]};
            man_b_r     <= {2'b01, B[22:0]};
            shift_cnt_r <= 5'd0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b1;
            if (a_zero_s || b_zero_s) begin
              if (a_zero_s && b_zero_s) begin
                diff_r <= 32'd0;
              end else if (a_zero_s) begin
                diff_r <= {~B[31], B[30:0]};
              end else begin
                diff_r <= A;
              end
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end else begin
              state_r <= ALIGN;
            end
          end
        end

        ALIGN: begin
          if (exp_a_r == exp_b_r) begin
            state_r <= ADD;
          end else if (exp_a_r > exp_b_r) begin
            shift_cnt_r <= shift_cnt_r + 5'd1;
            if (shift_cnt_r == 5'd24) begin
              man_b_r <= 25'd0;
              exp_b_r <= exp_a_r;
              state_r <= ADD;
            end else begin
              man_b_r <= man_b_r >> 1;
              exp_b_r <= exp_b_r + 8'd1;
              if (exp_b_r + 8'd1 == exp_a_r) begin
                state_r <= ADD;
              end
            end
          end else begin
            shift_cnt_r <= shift_cnt_r + 5'd1;
            if (shift_cnt_r == 5'd24) begin
              man_a_r <= 25'd0;
              exp_a_r <= exp_b_r;
              state_r <= ADD;
            end else begin
              man_a_r <= man_a_r >> 1;
              exp_a_r <= exp_a_r + 8'd1;
              if (exp_a_r + 8'd1 == exp_b_r) begin
                state_r <= ADD;
              end
            end
          end
        end

        ADD: begin
          res_exp_r <= exp_a_r;
          if (sign_a_r == sign_b_r) begin
            res_man_r  <= man_a_r + man_b_r;
            res_sign_r <= sign_a_r;
            state_r    <= NORM;
          end else if (man_a_r > man_b_r) begin
            res_man_r  <= man_a_r - man_b_r;
            res_sign_r <= sign_a_r;
            state_r    <= NORM;
          end else if (man_b_r > man_a_r) begin
            res_man_r  <= man_b_r - man_a_r;
            res_sign_r <= sign_b_r;
            state_r    <= NORM;
          end else begin
            diff_r      <= 32'd0;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end

        NORM: begin
          if (res_man_r[24]) begin
            if (exp_inc_s >= 9'h0FF) begin
              diff_r     <= {res_sign_r, 8'hFF, 23'd0};
              overflow_r <= 1'b1;
            end else begin
              diff_r <= {res_sign_r, exp_inc_s[7:0], res_man_r[23:1]};
            end
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else if (!res_man_r[23]) begin
            // Another left shift would push the exponent below 1
            if (res_exp_r <= 8'd1) begin
              diff_r      <= 32'd0;
              underflow_r <= 1'b1;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end else begin
              res_man_r <= res_man_r << 1;
              res_exp_r <= res_exp_r - 8'd1;
            end
          end else begin
            if (res_exp_r == 8'hFF) begin
              diff_r     <= {res_sign_r, 8'hFF, 23'd0};
              overflow_r <= 1'b1;
            end else begin
              diff_r <= {res_sign_r, res_exp_r, res_man_r[22:0]};
            end
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end

        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;
  assign busy      = busy_r;

endmodule

// File: doc/fp_subtractor_seq.md
FP_SUBTRACTOR_SEQ -- requirements
Module: fp_subtractor_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk        input   1   clock; all state changes on rising edge
- rst        input   1   asynchronous, active-high reset
- in_valid   input   1   operand pair A, B offered
- in_ready   output  1   block can accept operands
- A          input  32   IEEE-754 single minuend
- B          input  32   IEEE-754 single subtrahend
- out_valid  output  1   diff and flags valid
- out_ready  input   1   consumer accepts result
- diff       output 32   A - B, single precision, truncated
- overflow   output  1   result exponent reached 0xFF
- underflow  output  1   result exponent fell below 0x01
- busy       output  1   state is not IDLE

Function
REQ-003 SHALL implement states IDLE, ALIGN, ADD, NORM, DONE.
REQ-004 IDLE: in_ready=1, busy=0; in_valid=1 captures A and B with B[31] inverted (A + (-B)).
REQ-005 A capture SHALL go to DONE if either operand is zero (bits[30:0]==0), otherwise to ALIGN.
REQ-006 Zero path results:
- A zero, B nonzero: diff = {~B[31], B[30:0]}
- B zero, A nonzero: diff = A
- both zero: diff = 0x00000000
REQ-007 Mantissas SHALL be 25-bit {1'b0, 1'b1, frac[22:0]} for every nonzero operand, including exponent 0; no NaN/Inf special-casing; exponent 0xFF inputs are treated as ordinary numbers.
REQ-008 ALIGN: each cycle with unequal exponents, the smaller-exponent mantissa SHALL shift right 1 bit, truncated, and its exponent increments by 1.
REQ-009 ALIGN exit: at 25 shifts, that mantissa SHALL be forced to 0 and exponents set equal; with equal exponents the next state is ADD; ALIGN lasts at least 1 cycle.
REQ-010 ADD (1 cycle), same signs: mantissa = sum of magnitudes, sign kept.
REQ-011 ADD, different signs: mantissa = larger magnitude - smaller, sign of the larger; equal magnitudes -> diff = 0x00000000 and go to DONE.
REQ-012 NORM: bit24=1 -> shift right 1, exponent +1 (one cycle); otherwise, bit23=0 -> shift left 1 per cycle, exponent -1, until bit23=1.
REQ-013 Overflow: exponent reaching 0xFF in NORM -> diff = {sign, 8'hFF, 23'h0}, overflow=1, go to DONE.
REQ-014 Underflow: left shift needing exponent < 0x01 -> diff = 0x00000000, underflow=1, go to DONE.
REQ-015 No guard, round or sticky bits; all shifted-out bits SHALL be discarded (truncation).
REQ-016 DONE: out_valid=1; diff, overflow, underflow held stable until out_valid && out_ready, then return to IDLE in the same edge.
REQ-017 in_ready SHALL be 0 outside IDLE; in_valid outside IDLE SHALL be ignored.
REQ-018 Latency SHALL be 1 (capture) + ALIGN cycles + 1 (ADD) + NORM cycles edges to out_valid; zero path reaches DONE on the cycle after capture.
REQ-019 Flags SHALL clear on every new capture.

Reset
REQ-020 rst=1 SHALL asynchronously force IDLE with:
- in_ready=1
- out_valid=0, busy=0
- diff=0x00000000, overflow=0, underflow=0
REQ-021 Reset in any state SHALL abort the operation, discard internal operands, and produce no out_valid pulse.
REQ-022 The first capture SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-023 Bench SHALL cover:
- A=0x40400000 (3.0), B=0x3F800000 (1.0) -> diff=0x40000000, 1 ALIGN shift, flags 0.
- A=0x3F800000, B=0x3F800000 -> diff=0x00000000, flags 0.
- A=0x3F800000, B=0xBF800000 -> diff=0x40000000 via one NORM right shift.
- A=0x3F800000, B=0x3F7FFFFF -> diff=0x34000000 (truncated alignment, 23 left shifts).
- A=0x7F7FFFFF, B=0xFF7FFFFF -> diff=0x7F800000, overflow=1.
- Hold out_ready=0 for 5 cycles in DONE -> diff stable, in_ready=0; separately, pulse rst mid-ALIGN -> IDLE next, out_valid stays 0, then a fresh operation completes correctly.
